cell_sweep_driver: RTL and testbench
====================================

# cell_sweep_driver

Sequential stimulus and capture engine for combinational cell power characterisation. It drives the five inputs of an AO221-type cell (Q = IN1&IN2 | IN3&IN4 | IN5) through exhaustive input sweeps, samples the cell output, and counts output toggles (for switching-power estimation) and functional mismatches. It sits in the power-test harness between the bench controller and the cell under test.

## Interface
- HOLD_CYCLES, 2: cycles each vector is held before QIN is sampled; legal range 1..255.
- CNT_W, 16: width of TOGGLE_CNT and ERR_CNT; legal range ≥ 4.

- CLK  in  1  sole clock; all state changes on the rising edge.
- RSTB  in  1  asynchronous, active-low reset.
- START  in  1  begins a sweep when sampled high while idle.
- MODE  in  1  0 = binary order; 1 = Gray order.
- REPEAT  in  8  number of full 32-vector sweeps; 0 is treated as 1; latched at START.
- VEC  out  5  cell stimulus: VEC[0]→IN1, VEC[1]→IN2, VEC[2]→IN3, VEC[3]→IN4, VEC[4]→IN5.
- QIN  in  1  cell output Q, treated as synchronous to CLK.
- BUSY  out  1  high while a sweep is in progress.
- DONE  out  1  one-cycle pulse after the last sample.
- TOGGLE_CNT  out  CNT_W  count of sampled QIN transitions.
- ERR_CNT  out  CNT_W  count of samples where QIN ≠ expected Q.

## Operation
- FSM states: IDLE, RUN, FIN.
  - IDLE→RUN on START=1.
  - RUN→FIN after the final sample.
  - FIN→IDLE unconditionally after one cycle. DONE=1 only in FIN.
- On START acceptance: latch MODE and REPEAT (0→1); clear TOGGLE_CNT, ERR_CNT, the 5-bit index, the sweep counter, and the prev-sample-valid flag.
- START is ignored in RUN and FIN. MODE and REPEAT changes during RUN are ignored.
- VEC = idx in binary mode; VEC = idx ^ (idx>>1) in Gray mode. VEC = 0 in IDLE and FIN.
- The index advances 0..31 and wraps 31→0, which increments the sweep counter. The run ends after sample 32×REPEAT.
- Expected value = (VEC[0]&VEC[1]) | (VEC[2]&VEC[3]) | VEC[4], computed from the VEC currently driven.
- At each sample:
  - ERR_CNT += (QIN ≠ expected).
  - If prev-sample-valid, TOGGLE_CNT += (QIN ≠ prev).
  - Store QIN as prev and set prev-sample-valid.
  - Both counters saturate at 2^CNT_W−1 and never wrap.
  - The previous sample carries across sweep boundaries, so the 31→0 wrap can count a toggle.
- Counters hold their final values in IDLE until the next START or a reset.
- RSTB low at any time, including mid-sweep, asynchronously forces: state IDLE, VEC=0, BUSY=0, DONE=0, both counters 0, index/sweep/hold counters 0.

## Timing
- Reset values: VEC=0, BUSY=0, DONE=0, TOGGLE_CNT=0, ERR_CNT=0.
- START sampled high at edge t: BUSY=1 and VEC = first vector (0) from t+1.
- Each vector is held exactly HOLD_CYCLES cycles with no gap.
- QIN is sampled at the edge ending the vector's last hold cycle; VEC changes on that same edge.
- BUSY duration = 32 × REPEAT × HOLD_CYCLES cycles.
- On the edge of the final sample: BUSY→0, DONE→1 for one cycle, VEC→0. Counters are final in the DONE cycle.
- A START asserted during the DONE cycle is ignored. The earliest restart is START sampled in the following IDLE cycle.

## Test plan
- Binary sweep: MODE=0, REPEAT=1, HOLD_CYCLES=2, ideal AO221 model on QIN → BUSY high 64 cycles, DONE one pulse, ERR_CNT=0, TOGGLE_CNT=5.
- Wrap toggle: same setup with REPEAT=2 → BUSY high 128 cycles, ERR_CNT=0, TOGGLE_CNT=11 (31→0 wrap adds 1).
- Stuck-at fault:
  - QIN tied 0, MODE=0, REPEAT=1 → ERR_CNT=23, TOGGLE_CNT=0.
  - QIN tied 1, MODE=1 → ERR_CNT=9, TOGGLE_CNT=0.
- Saturation: CNT_W=4, QIN tied 0, REPEAT=1 → ERR_CNT=15, holding at 15 after the run.
- Gray order and REPEAT=0: MODE=1, REPEAT=0, HOLD_CYCLES=1, ideal model → VEC changes exactly one bit per step (including 31→0, 10000→00000), 32 busy cycles, ERR_CNT=0.
- Reset and START rules:
  - START pulsed mid-run → no effect.
  - RSTB low at busy cycle 20 → all outputs 0 immediately, without waiting for a clock edge.
  - START after RSTB release → fresh run with results identical to the binary sweep case.

Source files
------------

// File: rtl/cell_sweep_driver.sv
// Sweeps the five inputs of an AO221 cell exhaustively (binary or Gray order),
// samples the cell output and counts output toggles and functional mismatches.
//
// state | meaning
// IDLE  | waiting for start; counters hold last results
// RUN   | driving vectors, sampling qin at the end of each hold window
// FIN   | one-cycle done pulse; start ignored
module cell_sweep_driver #(
    parameter int HOLD_CYCLES = 2,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             start,
    input  logic             mode,
    input  logic [7:0]       repeat_cnt,
    output logic [4:0]       vec,
    input  logic             qin,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] toggle_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    localparam logic [7:0]       HOLD_LOAD = 8'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    state_t     state, state_nxt;
    logic [4:0] idx;
    logic [7:0] sweep;
    logic [7:0] rep_l;
    logic [7:0] hold;
    logic       mode_l;
    logic       prev;
    logic       prev_vld;
    logic       sample;
    logic       last_sample;
    logic       expected;

    assign sample      = (state == RUN) && (hold == 8'd0);
    assign last_sample = sample && (idx == 5'd31) && (sweep == rep_l - 8'd1);
    assign expected    = (vec[0] & vec[1]) | (vec[2] & vec[3]) | vec[4];

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        vec       = 5'd0;
        case (state)
            IDLE: begin
                if (start) state_nxt = RUN;
            end
            RUN: begin
                busy = 1'b1;
                vec  = mode_l ? (idx ^ (idx >> 1)) : idx;
                if (last_sample) state_nxt = FIN;
            end
            FIN: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) state <= IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            idx        <= 5'd0;
            sweep      <= 8'd0;
            rep_l      <= 8'd0;
            hold       <= 8'd0;
            mode_l     <= 1'b0;
            prev       <= 1'b0;
            prev_vld   <= 1'b0;
            toggle_cnt <= '0;
            err_cnt    <= '0;
        end else if (state == IDLE && start) begin
            mode_l     <= mode;
            rep_l      <= (repeat_cnt == 8'd0) ? 8'd1 : repeat_cnt;
            idx        <= 5'd0;
            sweep      <= 8'd0;
            hold       <= HOLD_LOAD;
            prev       <= 1'b0;
            prev_vld   <= 1'b0;
            toggle_cnt <= '0;
            err_cnt    <= '0;
        end else if (state == RUN) begin
            if (hold != 8'd0) begin
                hold <= hold - 8'd1;
            end else begin
                // End of the hold window: sample and move to the next vector
                hold <= HOLD_LOAD;
                idx  <= idx + 5'd1;
                if (idx == 5'd31) sweep <= sweep + 8'd1;
                if (qin != expected && err_cnt != CNT_MAX)
                    err_cnt <= err_cnt + 1'b1;
                if (prev_vld && qin != prev && toggle_cnt != CNT_MAX)
                    toggle_cnt <= toggle_cnt + 1'b1;
                prev     <= qin;
                prev_vld <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cell_sweep_driver.sv
// Bench for cell_sweep_driver: two instances (hold 2 / 16-bit counters and
// hold 1 / 4-bit counters) checked every cycle against a sweep-level model.
module tb_cell_sweep_driver;

    localparam int HOLD[2] = '{2, 1};
    localparam int CMAX[2] = '{65535, 15};

    logic       clk  = 1'b0;
    logic       rstb = 1'b0;
    logic       start [2];
    logic       mode  [2];
    logic       qin   [2];
    logic       busy_o[2];
    logic       done_o[2];
    logic       rnd   [2];
    logic [7:0] rep   [2];
    logic [4:0] vec_o [2];
    int         qsel  [2];
    logic [15:0] tog0, err0;
    logic [3:0]  tog1, err1;
    int         a_tog[2], a_err[2];

    int n_chk  = 0;
    int n_fail = 0;
    bit cmp_en = 1'b0;

    // behavioural model state
    bit m_act[2], m_done[2], m_mode[2], m_prev[2], m_pv[2];
    int m_k[2], m_tot[2], m_tog[2], m_err[2];

    always #5 clk = ~clk;

    cell_sweep_driver #(.HOLD_CYCLES(2), .CNT_W(16)) dut0 (
        .clk(clk), .rstb(rstb), .start(start[0]), .mode(mode[0]),
        .repeat_cnt(rep[0]), .vec(vec_o[0]), .qin(qin[0]), .busy(busy_o[0]),
        .done(done_o[0]), .toggle_cnt(tog0), .err_cnt(err0)
    );

    cell_sweep_driver #(.HOLD_CYCLES(1), .CNT_W(4)) dut1 (
        .clk(clk), .rstb(rstb), .start(start[1]), .mode(mode[1]),
        .repeat_cnt(rep[1]), .vec(vec_o[1]), .qin(qin[1]), .busy(busy_o[1]),
        .done(done_o[1]), .toggle_cnt(tog1), .err_cnt(err1)
    );

    assign a_tog[0] = int'(tog0);
    assign a_err[0] = int'(err0);
    assign a_tog[1] = int'(tog1);
    assign a_err[1] = int'(err1);

    function automatic int vecf(int idx, bit gray);
        return gray ? (idx ^ (idx >> 1)) : idx;
    endfunction

    function automatic logic ao221(int v);
        return 1'(((v & (v >> 1)) | ((v >> 2) & (v >> 3)) | (v >> 4)) & 1);
    endfunction

    function automatic logic qsrc(logic [4:0] v, int s, logic r);
        case (s)
            0:       return ao221(int'(v));
            1:       return 1'b0;
            2:       return 1'b1;
            default: return r;
        endcase
    endfunction

    assign qin[0] = qsrc(vec_o[0], qsel[0], rnd[0]);
    assign qin[1] = qsrc(vec_o[1], qsel[1], rnd[1]);

    task automatic chk(string name, int act, int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    initial forever begin
        @(negedge clk);
        rnd[0] = 1'($urandom & 1);
        rnd[1] = 1'($urandom & 1);
    end

    // model: a run is 32*R*H cycles; a sample closes every H-th cycle
    initial forever begin
        @(posedge clk or negedge rstb);
        for (int i = 0; i < 2; i++) begin
            if (!rstb) begin
                m_act[i] = 0; m_done[i] = 0; m_k[i] = 0;
                m_tog[i] = 0; m_err[i] = 0; m_pv[i] = 0; m_prev[i] = 0;
            end else if (m_done[i]) begin
                m_done[i] = 0;
            end else if (m_act[i]) begin
                if ((m_k[i] + 1) % HOLD[i] == 0) begin
                    int v;
                    v = vecf((m_k[i] / HOLD[i]) % 32, m_mode[i]);
                    if (qin[i] != ao221(v) && m_err[i] < CMAX[i]) m_err[i]++;
                    if (m_pv[i] && qin[i] != m_prev[i] && m_tog[i] < CMAX[i]) m_tog[i]++;
                    m_prev[i] = qin[i];
                    m_pv[i]   = 1;
                end
                m_k[i]++;
                if (m_k[i] == m_tot[i]) begin
                    m_act[i]  = 0;
                    m_done[i] = 1;
                end
            end else if (start[i]) begin
                m_act[i]  = 1;
                m_k[i]    = 0;
                m_tot[i]  = 32 * ((rep[i] == 8'd0) ? 1 : int'(rep[i])) * HOLD[i];
                m_mode[i] = mode[i];
                m_tog[i]  = 0;
                m_err[i]  = 0;
                m_pv[i]   = 0;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (cmp_en) begin
            for (int i = 0; i < 2; i++) begin
                int ev;
                ev = m_act[i] ? vecf((m_k[i] / HOLD[i]) % 32, m_mode[i]) : 0;
                chk($sformatf("vec%0d", i),  int'(vec_o[i]),  ev);
                chk($sformatf("busy%0d", i), int'(busy_o[i]), int'(m_act[i]));
                chk($sformatf("done%0d", i), int'(done_o[i]), int'(m_done[i]));
                chk($sformatf("tog%0d", i),  a_tog[i],        m_tog[i]);
                chk($sformatf("err%0d", i),  a_err[i],        m_err[i]);
            end
        end
    end

    task automatic run(input int i, input bit md, input int rp, input int qs,
                       input int pulse_at, input bit start_in_done, input bit gchk,
                       output int bn, output int tog, output int err);
        bit         got;
        bit         first;
        logic [4:0] pv;
        @(negedge clk);
        qsel[i]  = qs;
        mode[i]  = md;
        rep[i]   = 8'(rp);
        start[i] = 1'b1;
        bn = 0; got = 0; first = 1; pv = 5'd0;
        for (int c = 0; c < 20000 && !got; c++) begin
            @(negedge clk);
            start[i] = 1'b0;
            if (busy_o[i]) begin
                if (gchk) begin
                    if (first) chk("gray_first", int'(vec_o[i]), 0);
                    else       chk("gray_step", $countones(vec_o[i] ^ pv), 1);
                    pv    = vec_o[i];
                    first = 0;
                end
                if (bn == pulse_at) begin
                    start[i] = 1'b1;
                    mode[i]  = ~md;
                    rep[i]   = 8'd7;
                end
                bn++;
            end
            if (done_o[i]) got = 1;
        end
        chk("done_seen", int'(got), 1);
        if (gchk) chk("gray_last", int'(pv), 16);
        tog = a_tog[i];
        err = a_err[i];
        if (start_in_done) start[i] = 1'b1;
        @(negedge clk);
        start[i] = 1'b0;
        mode[i]  = md;
        chk("done_pulse", int'(done_o[i]), 0);
        chk("idle_after", int'(busy_o[i]), 0);
    endtask

    initial begin
        int bn, tog, err;
        for (int i = 0; i < 2; i++) begin
            start[i] = 0; mode[i] = 0; rep[i] = 8'd1; qsel[i] = 0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("rst_vec",  int'(vec_o[i]),  0);
            chk("rst_busy", int'(busy_o[i]), 0);
            chk("rst_done", int'(done_o[i]), 0);
            chk("rst_tog",  a_tog[i], 0);
            chk("rst_err",  a_err[i], 0);
        end
        #1 rstb = 1'b1;
        cmp_en = 1'b1;

        run(0, 0, 1, 0, -1, 1, 0, bn, tog, err);
        chk("bin_busy", bn, 64); chk("bin_tog", tog, 5); chk("bin_err", err, 0);

        run(0, 0, 2, 0, -1, 0, 0, bn, tog, err);
        chk("wrap_busy", bn, 128); chk("wrap_tog", tog, 11); chk("wrap_err", err, 0);

        run(0, 0, 1, 1, -1, 0, 0, bn, tog, err);
        chk("sa0_err", err, 23); chk("sa0_tog", tog, 0);

        run(0, 1, 1, 2, -1, 0, 0, bn, tog, err);
        chk("sa1_err", err, 9); chk("sa1_tog", tog, 0);

        run(1, 0, 1, 1, -1, 0, 0, bn, tog, err);
        chk("sat_err", err, 15);
        repeat (5) @(negedge clk);
        chk("sat_hold", a_err[1], 15);

        run(1, 1, 0, 0, -1, 0, 1, bn, tog, err);
        chk("gray_busy", bn, 32); chk("gray_err", err, 0);

        run(0, 0, 1, 0, 30, 0, 0, bn, tog, err);
        chk("midstart_busy", bn, 64); chk("midstart_tog", tog, 5); chk("midstart_err", err, 0);

        // asynchronous reset in the middle of a run
        @(negedge clk);
        qsel[0] = 0; mode[0] = 0; rep[0] = 8'd1; start[0] = 1'b1;
        bn = 0;
        for (int c = 0; c < 200 && bn < 20; c++) begin
            @(negedge clk);
            start[0] = 1'b0;
            if (busy_o[0]) bn++;
        end
        chk("pre_rst_busy", bn, 20);
        #2 rstb = 1'b0;
        #1;
        chk("arst_vec",  int'(vec_o[0]),  0);
        chk("arst_busy", int'(busy_o[0]), 0);
        chk("arst_done", int'(done_o[0]), 0);
        chk("arst_tog",  a_tog[0], 0);
        chk("arst_err",  a_err[0], 0);
        @(negedge clk);
        #1 rstb = 1'b1;

        run(0, 0, 1, 0, -1, 0, 0, bn, tog, err);
        chk("post_rst_busy", bn, 64); chk("post_rst_tog", tog, 5); chk("post_rst_err", err, 0);

        for (int n = 0; n < 6; n++) begin
            int i;
            i = int'($urandom_range(0, 1));
            run(i, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)), -1, 0, 0, bn, tog, err);
        end

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
